// File: rtl/grf_sb_pkg.sv
// Shared CPU constants: default register-file geometry and trace-slice indices.
package grf_sb_pkg;
    localparam int GRF_DATA_W = 32;
    localparam int GRF_ADDR_W = 5;
    localparam int GRF_NUM_RD = 2;
    localparam int PC_W       = 32;
    localparam int TR_A       = 0;
    localparam int TR_B       = 1;
endpackage

// File: rtl/grf_sb_pending.sv
// Register scoreboard: pending bits, per-port busy lookup and sticky double-reservation error.
// Updates in 1 cycle; busy is combinational. There is no backpressure.
module grf_sb_pending
    import grf_sb_pkg::*;
#(
    parameter int ADDR_W = GRF_ADDR_W,
    parameter int NUM_RD = GRF_NUM_RD
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wa_en,
    input  logic [ADDR_W-1:0]        wa_addr,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic                     rsv_err
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0] pending_q, pending_d;
    logic             rsv_err_q, rsv_err_d;
    logic             wa_hit, wb_hit, rsv_hit, rsv_wr;

    assign wa_hit  = wa_en  && (wa_addr  != '0);
    assign wb_hit  = wb_en  && (wb_addr  != '0);
    assign rsv_hit = rsv_en && (rsv_addr != '0);
    // A reservation on a register being written this cycle is a legal hand-over.
    assign rsv_wr  = (wa_hit && (wa_addr == rsv_addr)) || (wb_hit && (wb_addr == rsv_addr));

    always_comb begin
        pending_d = pending_q;
        if (wa_hit) pending_d[wa_addr] = 1'b0;
        if (wb_hit) pending_d[wb_addr] = 1'b0;
        if (rsv_hit) pending_d[rsv_addr] = 1'b1;
        rsv_err_d = rsv_err_q || (rsv_hit && pending_q[rsv_addr] && !rsv_wr);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pending_q <= '0;
            rsv_err_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
            rsv_err_q <= rsv_err_d;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_busy
        logic [ADDR_W-1:0] ra;
        assign ra = rd_addr[k*ADDR_W +: ADDR_W];
        assign rd_busy[k] = (ra != '0) && pending_q[ra]
                          && !(wa_hit && (wa_addr == ra))
                          && !(wb_hit && (wb_addr == ra));
    end

    assign rsv_err = rsv_err_q;
endmodule

// File: rtl/grf_sb.sv
// Register file with write-first bypass, two writeback ports, scoreboard and write trace.
// Reads 0 cycles, storage/trace 1 cycle; no backpressure, writes always accepted.
module grf_sb
    import grf_sb_pkg::*;
#(
    parameter int DATA_W = GRF_DATA_W,
    parameter int ADDR_W = GRF_ADDR_W,
    parameter int NUM_RD = GRF_NUM_RD
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wa_en,
    input  logic [ADDR_W-1:0]        wa_addr,
    input  logic [DATA_W-1:0]        wa_data,
    input  logic [PC_W-1:0]          wa_pc,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic [PC_W-1:0]          wb_pc,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic                     rsv_err,
    output logic [1:0]               trace_vld,
    output logic [2*PC_W-1:0]        trace_pc,
    output logic [2*ADDR_W-1:0]      trace_addr,
    output logic [2*DATA_W-1:0]      trace_data
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0]   regs_q [DEPTH];
    logic [1:0]          trace_vld_q;
    logic [2*PC_W-1:0]   trace_pc_q;
    logic [2*ADDR_W-1:0] trace_addr_q;
    logic [2*DATA_W-1:0] trace_data_q;
    logic                wa_hit, wb_hit;

    assign wa_hit = wa_en && (wa_addr != '0);
    assign wb_hit = wb_en && (wb_addr != '0);

    // Port B is written last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
            trace_vld_q  <= '0;
            trace_pc_q   <= '0;
            trace_addr_q <= '0;
            trace_data_q <= '0;
        end else begin
            if (wa_hit) regs_q[wa_addr] <= wa_data;
            if (wb_hit) regs_q[wb_addr] <= wb_data;
            trace_vld_q <= {wb_hit, wa_hit};
            if (wa_hit) begin
                trace_pc_q[TR_A*PC_W +: PC_W]       <= wa_pc;
                trace_addr_q[TR_A*ADDR_W +: ADDR_W] <= wa_addr;
                trace_data_q[TR_A*DATA_W +: DATA_W] <= wa_data;
            end
            if (wb_hit) begin
                trace_pc_q[TR_B*PC_W +: PC_W]       <= wb_pc;
                trace_addr_q[TR_B*ADDR_W +: ADDR_W] <= wb_addr;
                trace_data_q[TR_B*DATA_W +: DATA_W] <= wb_data;
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        assign ra = rd_addr[k*ADDR_W +: ADDR_W];
        assign rd_data[k*DATA_W +: DATA_W] =
            (ra == '0)                   ? '0      :
            (wb_hit && (wb_addr == ra))  ? wb_data :
            (wa_hit && (wa_addr == ra))  ? wa_data :
                                           regs_q[ra];
    end

    grf_sb_pending #(
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD)
    ) u_pending (
        .clk      (clk),
        .reset    (reset),
        .rd_addr  (rd_addr),
        .rd_busy  (rd_busy),
        .wa_en    (wa_en),
        .wa_addr  (wa_addr),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .rsv_err  (rsv_err)
    );

    assign trace_vld  = trace_vld_q;
    assign trace_pc   = trace_pc_q;
    assign trace_addr = trace_addr_q;
    assign trace_data = trace_data_q;
endmodule

// File: tb/tb_grf_sb.sv
// Directed checks of the register file: reset, bypass, priority, reg 0, scoreboard, trace.
module tb_grf_sb;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]  rd_busy;
    logic           wa_en, wb_en, rsv_en;
    logic [AW-1:0]  wa_addr, wb_addr, rsv_addr;
    logic [DW-1:0]  wa_data, wb_data;
    logic [31:0]    wa_pc, wb_pc;
    logic           rsv_err;
    logic [1:0]     trace_vld;
    logic [63:0]    trace_pc;
    logic [2*AW-1:0] trace_addr;
    logic [2*DW-1:0] trace_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    grf_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
        .clk        (clk),
        .reset      (reset),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .wa_en      (wa_en),
        .wa_addr    (wa_addr),
        .wa_data    (wa_data),
        .wa_pc      (wa_pc),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .wb_pc      (wb_pc),
        .rsv_en     (rsv_en),
        .rsv_addr   (rsv_addr),
        .rsv_err    (rsv_err),
        .trace_vld  (trace_vld),
        .trace_pc   (trace_pc),
        .trace_addr (trace_addr),
        .trace_data (trace_data)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        wa_en = 0; wa_addr = '0; wa_data = '0; wa_pc = '0;
        wb_en = 0; wb_addr = '0; wb_data = '0; wb_pc = '0;
        rsv_en = 0; rsv_addr = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    initial begin
        idle();
        set_rd(5'd3, 5'd0);
        reset = 1'b0;
        // Write presented during reset must be discarded.
        wa_en = 1; wa_addr = 5'd3; wa_data = 32'h1234; wa_pc = 32'h40;
        step();
        step();
        idle();
        #1;
        chk("rst_rd3", {32'h0, rd_data[31:0]}, 64'h0);
        chk("rst_tvld", {62'h0, trace_vld}, 64'h0);
        chk("rst_tdata", trace_data, 64'h0);
        chk("rst_err", {63'h0, rsv_err}, 64'h0);
        reset = 1'b1;
        step();
        chk("rel_rd3", {32'h0, rd_data[31:0]}, 64'h0);
        chk("rel_tvld", {62'h0, trace_vld}, 64'h0);

        // Both ports write addr 5: B wins, both traced.
        set_rd(5'd5, 5'd5);
        wa_en = 1; wa_addr = 5'd5; wa_data = 32'hAAAA0000; wa_pc = 32'h100;
        wb_en = 1; wb_addr = 5'd5; wb_data = 32'h0000_5555; wb_pc = 32'h104;
        #1;
        chk("byp_b_pri", {32'h0, rd_data[31:0]}, 64'h5555);
        step();
        idle();
        #1;
        chk("pri_stored", {32'h0, rd_data[63:32]}, 64'h5555);
        chk("pri_tvld", {62'h0, trace_vld}, 64'h3);
        chk("pri_tdata", trace_data, 64'h0000_5555_AAAA_0000);
        chk("pri_tpc", trace_pc, 64'h0000_0104_0000_0100);
        chk("pri_taddr", {54'h0, trace_addr}, {54'h0, 5'd5, 5'd5});

        // Port A only bypass on port 1 while port 0 reads stored value.
        set_rd(5'd5, 5'd6);
        wa_en = 1; wa_addr = 5'd6; wa_data = 32'h66; wa_pc = 32'h108;
        #1;
        chk("byp_a_rd", rd_data, {32'h66, 32'h5555});
        step();
        idle();
        #1;
        chk("a_tvld", {62'h0, trace_vld}, 64'h1);
        step();
        chk("tvld_drop", {62'h0, trace_vld}, 64'h0);

        // Register 0 ignores writes and reservations.
        set_rd(5'd0, 5'd0);
        wa_en = 1; wa_addr = 5'd0; wa_data = 32'hFFFFFFFF;
        wb_en = 1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
        rsv_en = 1; rsv_addr = 5'd0;
        #1;
        chk("r0_byp", rd_data, 64'h0);
        step();
        idle();
        #1;
        chk("r0_rd", rd_data, 64'h0);
        chk("r0_tvld", {62'h0, trace_vld}, 64'h0);
        chk("r0_busy", {62'h0, rd_busy}, 64'h0);

        // Reserve 7, wait, then write it.
        set_rd(5'd7, 5'd0);
        rsv_en = 1; rsv_addr = 5'd7;
        step();
        idle();
        #1;
        chk("r7_busy1", {62'h0, rd_busy}, 64'h1);
        step();
        chk("r7_busy2", {62'h0, rd_busy}, 64'h1);
        wa_en = 1; wa_addr = 5'd7; wa_data = 32'h42; wa_pc = 32'h200;
        #1;
        chk("r7_mask", {62'h0, rd_busy}, 64'h0);
        chk("r7_byp", {32'h0, rd_data[31:0]}, 64'h42);
        step();
        idle();
        #1;
        chk("r7_clr", {62'h0, rd_busy}, 64'h0);
        chk("r7_rd", {32'h0, rd_data[31:0]}, 64'h42);
        chk("r7_taddr", {59'h0, trace_addr[4:0]}, 64'h7);
        chk("r7_tdata", {32'h0, trace_data[31:0]}, 64'h42);

        // Reservation and write to addr 4 in one cycle: reservation wins, no error.
        set_rd(5'd0, 5'd4);
        rsv_en = 1; rsv_addr = 5'd4;
        wa_en = 1; wa_addr = 5'd4; wa_data = 32'h10; wa_pc = 32'h300;
        step();
        idle();
        #1;
        chk("r4_data", {32'h0, rd_data[63:32]}, 64'h10);
        chk("r4_busy", {62'h0, rd_busy}, 64'h2);
        chk("r4_noerr", {63'h0, rsv_err}, 64'h0);
        wb_en = 1; wb_addr = 5'd4; wb_data = 32'h11; wb_pc = 32'h304;
        step();
        idle();
        #1;
        chk("r4_clr", {62'h0, rd_busy}, 64'h0);
        chk("r4_tvld", {62'h0, trace_vld}, 64'h2);
        chk("r4_tdata_b", {32'h0, trace_data[63:32]}, 64'h11);

        // Double reservation of 9 sets the sticky error.
        set_rd(5'd9, 5'd0);
        rsv_en = 1; rsv_addr = 5'd9;
        step();
        chk("r9_err0", {63'h0, rsv_err}, 64'h0);
        step();
        idle();
        #1;
        chk("r9_err1", {63'h0, rsv_err}, 64'h1);
        chk("r9_busy", {62'h0, rd_busy}, 64'h1);
        wa_en = 1; wa_addr = 5'd9; wa_data = 32'h99;
        step();
        idle();
        step();
        chk("r9_sticky", {63'h0, rsv_err}, 64'h1);
        chk("r9_busy_clr", {62'h0, rd_busy}, 64'h0);

        // Reset clears everything; first write after release behaves normally.
        set_rd(5'd5, 5'd7);
        reset = 1'b0;
        step();
        reset = 1'b1;
        #1;
        chk("rst2_err", {63'h0, rsv_err}, 64'h0);
        chk("rst2_rd", rd_data, 64'h0);
        set_rd(5'd2, 5'd0);
        wa_en = 1; wa_addr = 5'd2; wa_data = 32'h77; wa_pc = 32'h400;
        step();
        idle();
        #1;
        chk("post_rst_wr", {32'h0, rd_data[31:0]}, 64'h77);
        chk("post_rst_tvld", {62'h0, trace_vld}, 64'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/grf_sb.md
GRF_SB -- requirements
Module: grf_sb

Interface
REQ-001 Parameter DATA_W, default 32: register and data width in bits.
REQ-002 Parameter ADDR_W, default 5: register address width; depth is 2**ADDR_W.
REQ-003 Parameter NUM_RD, default 2: number of independent read ports.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-006 rd_addr  input  NUM_RD*ADDR_W  read addresses; port k occupies slice k.
REQ-007 rd_data  output  NUM_RD*DATA_W  read data per port, combinational.
REQ-008 rd_busy  output  NUM_RD  pending (reserved, not yet written) flag per port, combinational.
REQ-009 wa_en, wa_addr, wa_data, wa_pc  input  1/ADDR_W/DATA_W/32  write port A (older writeback).
REQ-010 wb_en, wb_addr, wb_data, wb_pc  input  1/ADDR_W/DATA_W/32  write port B (younger writeback; higher priority).
REQ-011 rsv_en, rsv_addr  input  1/ADDR_W  reservation request: mark a destination register pending.
REQ-012 rsv_err  output  1  sticky protocol-error flag.
REQ-013 trace_vld  output  2  registered write-trace valid; bit 0 = port A, bit 1 = port B.
REQ-014 trace_pc, trace_addr, trace_data  output  2*32/2*ADDR_W/2*DATA_W  registered trace fields; slice 0 = port A, slice 1 = port B.

Function
REQ-015 Register 0 SHALL always read 0, ignore writes, never become pending and never produce a trace.
REQ-016 A write on an enabled port with a nonzero address SHALL update that register at the next rising edge.
REQ-017 If both ports write the same nonzero address in one cycle, port B's data SHALL be stored.
REQ-018 rd_data SHALL use write-first bypass: a port B address match returns wb_data, else a port A match returns wa_data, else the stored value.
REQ-019 A pending bit SHALL be set on a rising edge with rsv_en and a nonzero rsv_addr.
REQ-020 A pending bit SHALL be cleared on a rising edge when either write port writes that address.
REQ-021 If a reservation and a write target the same address in one cycle, the pending bit SHALL end set (reservation wins).
REQ-022 rd_busy[k] SHALL equal pending[rd_addr_k], masked to 0 when a same-cycle write to that address is present; it is 0 for address 0.
REQ-023 A reservation targeting an already-pending register that is not being written in the same cycle SHALL set rsv_err, and the pending bit SHALL stay set.
REQ-024 rsv_err SHALL remain set until reset.
REQ-025 For each port writing a nonzero address, trace_vld for that port SHALL assert for exactly the following cycle, with the captured pc, addr and data (the written value).
REQ-026 When both ports write the same address, both traces SHALL be emitted.
REQ-027 trace_vld SHALL be 0 in every cycle not covered by REQ-025.
REQ-028 Latency: write to storage is 1 cycle, write to trace is 1 cycle, and reads (via bypass) have 0 cycles of latency.

Reset
REQ-029 While reset is low at a rising edge, all registers, pending bits, trace_vld, trace fields and rsv_err SHALL be cleared to 0.
REQ-030 Reset SHALL take priority over writes and reservations presented in the same cycle; none of them take effect.
REQ-031 The first writes or reservations sampled with reset high SHALL behave normally.

Structure
REQ-032 Default parameter values and the trace-slice index constants (TR_A=0, TR_B=1) SHALL live in the shared CPU package.
REQ-033 The scoreboard (pending bits, rd_busy masking, rsv_err) SHALL be a sub-module named grf_sb_pending.
REQ-034 The storage array, bypass and trace logic SHALL remain in grf_sb.

Verification
REQ-035 Reset low with wa_en=1, wa_addr=3, wa_data=0x1234 -> after reset is released, reg 3 reads 0 and trace_vld=0.
REQ-036 Same cycle: wa (addr 5, data 0xAAAA0000) and wb (addr 5, data 0x5555) -> rd_data reads 0x5555 in that cycle and after the edge; trace_vld=2'b11 on the next cycle.
REQ-037 Write addr 0 with data 0xFFFFFFFF on both ports -> rd_data for addr 0 is 0 and trace_vld stays 0.
REQ-038 Reserve addr 7, then after 2 cycles write addr 7 with data 0x42 -> rd_busy is 1 during the gap, 0 in the write cycle (masked), and 0 afterward; data reads 0x42.
REQ-039 Reserve addr 9 twice with no intervening write -> rsv_err=1 after the second edge, and it holds across later writes until reset.
REQ-040 Same cycle: reserve addr 4 and wa writes addr 4 with data 0x10 -> reg 4 = 0x10, pending set, and rd_busy=1 on the next cycle.
